// File: rtl/gp_register_bank_if.sv
// Control/status bundle for gp_register_bank: load, assert and count strobes with selects, plus carry/fault.
// The master drives the controls and the bank (slave) returns the registered flags.
interface gp_register_bank_if #(
    parameter int NUM_REGS = 4
);
    localparam int SELW = $clog2(NUM_REGS);

    logic            load_n;
    logic [SELW-1:0] load_sel;
    logic            a_main_n;
    logic [SELW-1:0] a_main_sel;
    logic            a_lhs_n;
    logic [SELW-1:0] a_lhs_sel;
    logic            a_rhs_n;
    logic [SELW-1:0] a_rhs_sel;
    logic            inc_n;
    logic            dec_n;
    logic [SELW-1:0] cnt_sel;
    logic            clr_fault_n;
    logic            carry;
    logic            fault;

    modport master (
        output load_n, load_sel, a_main_n, a_main_sel, a_lhs_n, a_lhs_sel,
               a_rhs_n, a_rhs_sel, inc_n, dec_n, cnt_sel, clr_fault_n,
        input  carry, fault
    );

    modport slave (
        input  load_n, load_sel, a_main_n, a_main_sel, a_lhs_n, a_lhs_sel,
               a_rhs_n, a_rhs_sel, inc_n, dec_n, cnt_sel, clr_fault_n,
        output carry, fault
    );
endinterface

// File: rtl/gp_register_bank.sv
// Bank of NUM_REGS WIDTH-bit registers with tri-state main/LHS/RHS assert ports, in-place inc/dec and a sticky fault.
// Asserts are combinational (zero latency); load/count/flags update in one cycle; no backpressure.
module gp_register_bank #(
    parameter int                WIDTH     = 8,
    parameter int                NUM_REGS  = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    inout  wire  [WIDTH-1:0]   main_bus,
    output wire  [WIDTH-1:0]   lhs_bus,
    output wire  [WIDTH-1:0]   rhs_bus,
    gp_register_bank_if.slave  ctl
);
    localparam int SELW = $clog2(NUM_REGS);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SELW-1:0]  sel_t;

    word_t r_regs [NUM_REGS];
    logic  r_carry;
    logic  r_fault;

    word_t w_main_val, w_lhs_val, w_rhs_val, w_cnt_val;
    logic  w_main_ok, w_lhs_ok, w_rhs_ok, w_cnt_ok, w_load_ok;
    logic  w_load, w_cnt, w_up, w_wrap, w_fault_set;
    word_t w_load_dat, w_cnt_nxt;

    // Unmatched selects (out-of-range indices) leave the value at zero and the _ok flag low.
    always_comb begin
        w_main_val = '0;
        w_lhs_val  = '0;
        w_rhs_val  = '0;
        w_cnt_val  = '0;
        w_main_ok  = 1'b0;
        w_lhs_ok   = 1'b0;
        w_rhs_ok   = 1'b0;
        w_cnt_ok   = 1'b0;
        w_load_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ctl.a_main_sel == sel_t'(i)) begin
                w_main_val = r_regs[i];
                w_main_ok  = 1'b1;
            end
            if (ctl.a_lhs_sel == sel_t'(i)) begin
                w_lhs_val = r_regs[i];
                w_lhs_ok  = 1'b1;
            end
            if (ctl.a_rhs_sel == sel_t'(i)) begin
                w_rhs_val = r_regs[i];
                w_rhs_ok  = 1'b1;
            end
            if (ctl.cnt_sel == sel_t'(i)) begin
                w_cnt_val = r_regs[i];
                w_cnt_ok  = 1'b1;
            end
            if (ctl.load_sel == sel_t'(i)) begin
                w_load_ok = 1'b1;
            end
        end
    end

    // A move takes the source straight from the bank rather than through the tri-state net.
    assign w_load_dat = !ctl.a_main_n ? w_main_val : main_bus;
    assign w_load     = !ctl.load_n && w_load_ok;
    assign w_up       = !ctl.inc_n;
    assign w_cnt      = (ctl.inc_n != ctl.dec_n) && w_cnt_ok
                        && !(w_load && ctl.load_sel == ctl.cnt_sel);
    assign w_cnt_nxt  = w_up ? w_cnt_val + word_t'(1) : w_cnt_val - word_t'(1);
    assign w_wrap     = w_up ? (w_cnt_val == '1) : (w_cnt_val == '0);

    assign w_fault_set = (!ctl.inc_n && !ctl.dec_n)
                       || (!ctl.a_main_n && !w_main_ok)
                       || (!ctl.a_lhs_n  && !w_lhs_ok)
                       || (!ctl.a_rhs_n  && !w_rhs_ok)
                       || (!ctl.load_n   && !w_load_ok)
                       || ((!ctl.inc_n || !ctl.dec_n) && !w_cnt_ok);

    assign main_bus = (rst_n && !ctl.a_main_n) ? w_main_val : 'z;
    assign lhs_bus  = (rst_n && !ctl.a_lhs_n)  ? w_lhs_val  : 'z;
    assign rhs_bus  = (rst_n && !ctl.a_rhs_n)  ? w_rhs_val  : 'z;

    assign ctl.carry = r_carry;
    assign ctl.fault = r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
            r_carry <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_load && ctl.load_sel == sel_t'(i)) begin
                    r_regs[i] <= w_load_dat;
                end else if (w_cnt && ctl.cnt_sel == sel_t'(i)) begin
                    r_regs[i] <= w_cnt_nxt;
                end
            end
            if (w_cnt) r_carry <= w_wrap;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end else if (!ctl.clr_fault_n) begin
                r_fault <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gp_register_bank.sv
// Scoreboard bench for gp_register_bank (WIDTH=8, NUM_REGS=3 so select 3 is out of range, RESET_VAL=0x5A).
// Stimulus pushes expected bus/flag values per cycle; a negedge monitor pops and compares.
module tb_gp_register_bank;
    localparam int W = 8;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  [W-1:0] main_bus;
    wire  [W-1:0] lhs_bus;
    wire  [W-1:0] rhs_bus;
    logic         tb_en = 1'b0;
    logic [W-1:0] tb_dat = '0;

    assign main_bus = tb_en ? tb_dat : 'z;

    gp_register_bank_if #(.NUM_REGS(N)) u_if ();

    gp_register_bank #(.WIDTH(W), .NUM_REGS(N), .RESET_VAL(8'h5A)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .main_bus (main_bus),
        .lhs_bus  (lhs_bus),
        .rhs_bus  (rhs_bus),
        .ctl      (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       load_n; bit [1:0] load_sel;
        bit       am_n;   bit [1:0] am_sel;
        bit       al_n;   bit [1:0] al_sel;
        bit       ar_n;   bit [1:0] ar_sel;
        bit       inc_n;  bit dec_n; bit [1:0] cnt_sel;
        bit       clr_n;
        bit       drv_en; bit [7:0] drv;
    } stim_t;

    typedef struct {
        int       cyc;
        bit       chk_m, chk_l, chk_r;
        bit [7:0] m, l, r;
        bit       carry, fault;
    } exp_t;

    exp_t     q[$];
    int       n_cmp = 0;
    int       n_fail = 0;
    int       cyc = 0;

    bit [7:0] m_regs [N];
    bit       m_carry, m_fault;

    function automatic bit [7:0] m_rd(input bit [1:0] s);
        return (s < N) ? m_regs[s] : 8'h00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.load_n = 1; s.load_sel = 0; s.am_n = 1; s.am_sel = 0;
        s.al_n = 1; s.al_sel = 0; s.ar_n = 1; s.ar_sel = 0;
        s.inc_n = 1; s.dec_n = 1; s.cnt_sel = 0; s.clr_n = 1;
        s.drv_en = 0; s.drv = 0;
        return s;
    endfunction

    function automatic stim_t rd(input bit [1:0] l, input bit [1:0] r, input bit [1:0] m);
        stim_t s = idle();
        s.al_n = 0; s.al_sel = l; s.ar_n = 0; s.ar_sel = r; s.am_n = 0; s.am_sel = m;
        return s;
    endfunction

    function automatic stim_t ld(input bit [1:0] sel, input bit [7:0] v);
        stim_t s = idle();
        s.load_n = 0; s.load_sel = sel; s.drv_en = 1; s.drv = v;
        return s;
    endfunction

    function automatic bit [1:0] rsel();
        return ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, N - 1));
    endfunction

    task automatic apply(input stim_t s);
        u_if.load_n = s.load_n;   u_if.load_sel = s.load_sel;
        u_if.a_main_n = s.am_n;   u_if.a_main_sel = s.am_sel;
        u_if.a_lhs_n = s.al_n;    u_if.a_lhs_sel = s.al_sel;
        u_if.a_rhs_n = s.ar_n;    u_if.a_rhs_sel = s.ar_sel;
        u_if.inc_n = s.inc_n;     u_if.dec_n = s.dec_n;
        u_if.cnt_sel = s.cnt_sel; u_if.clr_fault_n = s.clr_n;
        tb_en = s.drv_en;         tb_dat = s.drv;
    endtask

    // Reference: what the bank must show this cycle, then what the coming edge does to it.
    task automatic model(input stim_t s);
        exp_t e;
        bit [7:0] ldv, v;
        bit fset, do_ld, do_cnt;
        e.cyc = cyc;
        e.chk_m = !s.am_n || s.drv_en;
        e.m = !s.am_n ? m_rd(s.am_sel) : s.drv;
        e.chk_l = !s.al_n; e.l = m_rd(s.al_sel);
        e.chk_r = !s.ar_n; e.r = m_rd(s.ar_sel);
        e.carry = m_carry; e.fault = m_fault;
        q.push_back(e);

        fset = (!s.inc_n && !s.dec_n) || (!s.am_n && s.am_sel >= N) || (!s.al_n && s.al_sel >= N)
            || (!s.ar_n && s.ar_sel >= N) || (!s.load_n && s.load_sel >= N)
            || ((!s.inc_n || !s.dec_n) && s.cnt_sel >= N);
        ldv    = !s.am_n ? m_rd(s.am_sel) : s.drv;
        do_ld  = !s.load_n && s.load_sel < N;
        do_cnt = (s.inc_n ^ s.dec_n) && s.cnt_sel < N && !(do_ld && s.load_sel == s.cnt_sel);
        if (do_cnt) begin
            v = m_regs[s.cnt_sel];
            if (!s.inc_n) begin
                m_carry = (v == 8'd255);
                m_regs[s.cnt_sel] = 8'((int'(v) + 1) % 256);
            end else begin
                m_carry = (v == 8'd0);
                m_regs[s.cnt_sel] = 8'((int'(v) + 255) % 256);
            end
        end
        if (do_ld) m_regs[s.load_sel] = ldv;
        if (fset) m_fault = 1'b1;
        else if (!s.clr_n) m_fault = 1'b0;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        cyc++;
        apply(s);
        model(s);
    endtask

    // Reset asserted mid-cycle with every assert active and the bench driving main_bus.
    task automatic do_reset();
        exp_t e;
        stim_t s = rd(0, 1, 2);
        @(posedge clk);
        #2;
        cyc++;
        s.drv_en = 1; s.drv = 8'hA5;
        apply(s);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) m_regs[i] = 8'h5A;
        m_carry = 0; m_fault = 0;
        e.cyc = cyc; e.chk_m = 1; e.m = 8'hA5; e.chk_l = 0; e.l = 0; e.chk_r = 0; e.r = 0;
        e.carry = 0; e.fault = 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        tb_en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic cmp(input string nm, input int c, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, got, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_m) cmp("main_bus", e.cyc, int'(main_bus), int'(e.m));
                if (e.chk_l) cmp("lhs_bus", e.cyc, int'(lhs_bus), int'(e.l));
                if (e.chk_r) cmp("rhs_bus", e.cyc, int'(rhs_bus), int'(e.r));
                cmp("carry", e.cyc, int'(u_if.carry), int'(e.carry));
                cmp("fault", e.cyc, int'(u_if.fault), int'(e.fault));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        apply(idle());
        repeat (2) @(posedge clk);
        do_reset();
        step(rd(0, 1, 2));

        step(ld(2, 8'h3C));
        step(rd(2, 2, 2));

        step(ld(1, 8'h11));
        step(ld(2, 8'hEE));
        s = idle(); s.am_n = 0; s.am_sel = 1; s.load_n = 0; s.load_sel = 2;
        step(s);
        step(rd(1, 2, 2));
        s = idle(); s.am_n = 0; s.am_sel = 1; s.load_n = 0; s.load_sel = 1;
        step(s);
        step(rd(1, 1, 0));

        step(ld(0, 8'hFF));
        s = idle(); s.inc_n = 0; s.cnt_sel = 0;
        step(s);
        step(rd(0, 0, 0));
        s = idle(); s.dec_n = 0; s.cnt_sel = 0;
        step(s);
        step(rd(0, 0, 0));
        s = idle(); s.inc_n = 0; s.cnt_sel = 0;
        step(s);
        step(rd(0, 0, 0));

        step(ld(2, 8'h07));
        s = idle(); s.inc_n = 0; s.dec_n = 0; s.cnt_sel = 2;
        step(s);
        step(rd(2, 2, 2));
        s = ld(2, 8'h40); s.inc_n = 0; s.cnt_sel = 2;
        step(s);
        step(rd(2, 2, 2));
        s = idle(); s.clr_n = 0;
        step(s);
        step(rd(0, 1, 2));
        s = idle(); s.inc_n = 0; s.cnt_sel = 0;
        step(s);
        step(rd(0, 0, 0));

        s = ld(1, 8'h20); s.inc_n = 0; s.cnt_sel = 2;
        step(s);
        step(rd(1, 2, 0));

        s = idle(); s.ar_n = 0; s.ar_sel = 3; s.al_n = 0; s.al_sel = 0;
        step(s);
        step(ld(3, 8'h99));
        s = idle(); s.dec_n = 0; s.cnt_sel = 3;
        step(s);
        step(rd(0, 1, 2));
        s = idle(); s.clr_n = 0; s.inc_n = 0; s.dec_n = 0;
        step(s);
        s = idle(); s.clr_n = 0;
        step(s);
        step(rd(0, 1, 2));

        for (int i = 0; i < 600; i++) begin
            s.load_n = ($urandom_range(0, 2) != 0); s.load_sel = rsel();
            s.am_n = ($urandom_range(0, 2) != 0);   s.am_sel = rsel();
            s.al_n = ($urandom_range(0, 1) != 0);   s.al_sel = rsel();
            s.ar_n = ($urandom_range(0, 1) != 0);   s.ar_sel = rsel();
            s.inc_n = ($urandom_range(0, 2) != 0);  s.dec_n = ($urandom_range(0, 2) != 0);
            s.cnt_sel = rsel();
            s.clr_n = ($urandom_range(0, 3) != 0);
            s.drv_en = s.am_n; s.drv = 8'($urandom);
            step(s);
        end

        step(ld(0, 8'h00));
        s = idle(); s.dec_n = 0; s.cnt_sel = 0; s.ar_n = 0; s.ar_sel = 3;
        step(s);
        step(rd(0, 0, 0));
        do_reset();
        step(rd(0, 1, 2));
        step(idle());

        repeat (3) @(posedge clk);
        cmp("scoreboard_drained", cyc, q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gp_register_bank.md
Name: gp_register_bank

Overview:
- Parametrised successor to the single 8-bit general purpose register: a bank of NUM_REGS registers, each WIDTH bits, sharing one main-bus load port and three independently addressed assert ports (main, LHS, RHS).
- Adds in-place increment/decrement with a registered carry/borrow flag and a sticky fault flag for illegal control combinations.
- Sits on the CPU datapath between the main bus and the ALU operand buses.
- A same-cycle assert-main plus load performs a register-to-register move.

Parameters:
- WIDTH, 8: register and bus width in bits (>=1).
- NUM_REGS, 4: number of registers (2..16).
- RESET_VAL, 0: value loaded into every register on reset.
- SELW, $clog2(NUM_REGS) (local, derived): width of every select field.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- main_bus  inout  WIDTH  shared main bus; driven only while asserting, otherwise high-Z.
- lhs_bus  output  WIDTH  ALU left operand bus; high-Z when not asserted.
- rhs_bus  output  WIDTH  ALU right operand bus; high-Z when not asserted.
- load_n  input  1  active low; load main_bus into register load_sel.
- load_sel  input  SELW  load target.
- a_main_n  input  1  active low; drive register a_main_sel onto main_bus.
- a_main_sel  input  SELW  main assert source.
- a_lhs_n  input  1  active low; drive register a_lhs_sel onto lhs_bus.
- a_lhs_sel  input  SELW  LHS assert source.
- a_rhs_n  input  1  active low; drive register a_rhs_sel onto rhs_bus.
- a_rhs_sel  input  SELW  RHS assert source.
- inc_n  input  1  active low; increment register cnt_sel.
- dec_n  input  1  active low; decrement register cnt_sel.
- cnt_sel  input  SELW  count target.
- carry  output  1  registered carry (inc wrap) or borrow (dec wrap) from the last count operation.
- fault  output  1  sticky fault flag.
- clr_fault_n  input  1  active low; synchronous clear of fault.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = RESET_VAL; carry = 0; fault = 0.
  - All three buses go high-Z immediately, independent of assert inputs.
  - Release is synchronous to the next clk edge.
- Assert paths are combinational from current register contents, so zero-cycle latency.
  - Each of main/LHS/RHS may select any register, including the same register on all three at once.
- Load: on the rising edge with load_n low, reg[load_sel] <= main_bus. New value is visible on assert paths from the following cycle.
- Move: a_main_n and load_n both low means reg[load_sel] <= reg[a_main_sel] at the edge.
  - If load_sel == a_main_sel, the value is unchanged.
- Count:
  - inc_n low: reg[cnt_sel] <= reg[cnt_sel] + 1, modulo 2^WIDTH.
  - dec_n low: reg[cnt_sel] <= reg[cnt_sel] - 1, modulo 2^WIDTH.
  - carry <= 1 only on all-ones -> 0 (inc) or 0 -> all-ones (dec); otherwise carry <= 0.
  - carry holds its value in cycles with no count operation.
- Priority: if load and count target the same register in one cycle, load wins, the count is dropped, and carry holds.
  - Load and count on different registers both take effect.
- inc_n and dec_n both low: no register change, carry holds, fault <= 1.
- Out-of-range select (index >= NUM_REGS, only possible when NUM_REGS is not a power of two):
  - An asserted bus drives all zeros.
  - A load or count to that index is ignored.
  - fault <= 1.
- Load sourced from main_bus while nothing in this bank asserts main is legal (external driver).
- fault clearing: clr_fault_n low clears fault at the edge; a new fault condition in the same cycle takes priority and fault stays 1.
- No internal pipeline; all state updates complete in one cycle.

Test Plan:
- Reset: WIDTH=8, NUM_REGS=4, RESET_VAL=0x5A; pulse rst_n low mid-cycle -> all regs 0x5A at once, buses Z, carry=0, fault=0.
- Load and read: drive main_bus=0x3C with load_n=0, load_sel=2; next cycle a_lhs_sel=2, a_rhs_sel=2, a_main_sel=2 -> lhs_bus, rhs_bus and main_bus all 0x3C.
- Move: reg1=0x11, reg3=0xEE; a_main_n=0, a_main_sel=1, load_n=0, load_sel=3 -> reg3=0x11, reg1 unchanged.
- Wrap: reg0=0xFF, inc_n=0 -> reg0=0x00, carry=1; then dec_n=0 -> reg0=0xFF, carry=1; then inc -> 0x00, carry=1; then inc -> 0x01, carry=0.
- Conflicts:
  - inc_n=dec_n=0 on reg2=0x07 -> reg2 stays 0x07, fault=1.
  - load 0x40 plus inc, both on reg2 -> reg2=0x40, carry held.
  - clr_fault_n=0 -> fault=0.
- Out of range: NUM_REGS=3; a_rhs_sel=3, a_rhs_n=0 -> rhs_bus=0x00, fault=1; load_sel=3 -> no register changes.
